// File: rtl/phase_seq_monitor.sv
//==============================================================================
// Module   : phase_seq_monitor
// Purpose  : Receive-side checker for a 4-phase one-hot clock-phase bus.
//            Encodes the phase lines to a 2-bit index, verifies the
//            0->1->2->3->0 rotation, declares lock, counts completed
//            rotations while locked and flags sequence faults.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters:
//   LOCK_N   consecutive in-order legal samples needed for lock (1..15)
//   CNT_W    width of Cycle_Count
//   HOLD_OK  1 = a repeated identical phase is tolerated (no advance, no error)
//
// Ports:
//   Phase_Count  in   clock, rising edge
//   Clear        in   asynchronous reset, active-high
//   Phase0..3    in   one-hot phase lines
//   Err_Clr      in   synchronous clear of Seq_Err (and Err_Count)
//   Phase_Idx    out  [1:0] index of the last legal sample
//   Phase_Valid  out  last sample was exactly one-hot
//   Locked       out  rotation verified (tracking)
//   Seq_Err      out  sticky sequence-fault flag
//   Cycle_Count  out  [CNT_W-1:0] completed 3->0 rotations while locked
//   Err_Count    out  [7:0] saturating fault counter
//                     (present only when PHASE_ERR_CNT_EN is defined)
//
// Optional build macro: PHASE_ERR_CNT_EN
//==============================================================================
`default_nettype none

module phase_seq_monitor #(
    parameter int LOCK_N  = 4,
    parameter int CNT_W   = 8,
    parameter bit HOLD_OK = 1'b0
) (
    input  logic             Phase_Count,
    input  logic             Clear,
    input  logic             Phase0,
    input  logic             Phase1,
    input  logic             Phase2,
    input  logic             Phase3,
    input  logic             Err_Clr,
    output logic [1:0]       Phase_Idx,
    output logic             Phase_Valid,
    output logic             Locked,
    output logic             Seq_Err,
    output logic [CNT_W-1:0] Cycle_Count
`ifdef PHASE_ERR_CNT_EN
    ,
    output logic [7:0]       Err_Count
`endif
);

    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_N);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        TRACK   = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] prev_idx;
    logic [3:0] good;

    // ------------------------------------------------------------------
    // One-hot decode of the sampled phase lines
    // ------------------------------------------------------------------
    logic [3:0] phases;
    logic       legal;
    logic [1:0] idx;
    logic [1:0] next_idx;
    logic       in_order;
    logic       hold;
    logic [3:0] good_inc;

    assign phases = {Phase3, Phase2, Phase1, Phase0};

    always_comb begin
        legal = 1'b0;
        idx   = 2'd0;
        case (phases)
            4'b0001: begin legal = 1'b1; idx = 2'd0; end
            4'b0010: begin legal = 1'b1; idx = 2'd1; end
            4'b0100: begin legal = 1'b1; idx = 2'd2; end
            4'b1000: begin legal = 1'b1; idx = 2'd3; end
            default: begin legal = 1'b0; idx = 2'd0; end
        endcase
    end

    // 2-bit arithmetic gives the mod-4 successor for free
    assign next_idx = prev_idx + 2'd1;
    assign in_order = legal && (idx == next_idx);
    assign hold     = legal && (idx == prev_idx);
    assign good_inc = good + 4'd1;

    // ------------------------------------------------------------------
    // Sequence FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Phase_Count or posedge Clear) begin
        if (Clear) begin
            state       <= HUNT;
            prev_idx    <= 2'd0;
            good        <= 4'd0;
            Phase_Idx   <= 2'd0;
            Phase_Valid <= 1'b0;
            Locked      <= 1'b0;
            Seq_Err     <= 1'b0;
            Cycle_Count <= '0;
`ifdef PHASE_ERR_CNT_EN
            Err_Count   <= 8'd0;
`endif
        end else begin
            Phase_Valid <= legal;
            if (legal) begin
                Phase_Idx <= idx;
            end

            // Clear first; a fault raised below on the same edge overrides it
            if (Err_Clr) begin
                Seq_Err <= 1'b0;
`ifdef PHASE_ERR_CNT_EN
                Err_Count <= 8'd0;
`endif
            end

            case (state)
                HUNT: begin
                    if (legal) begin
                        prev_idx <= idx;
                        good     <= 4'd1;
                        if (LOCK_TARGET == 4'd1) begin
                            state  <= TRACK;
                            Locked <= 1'b1;
                        end else begin
                            state  <= LOCKING;
                        end
                    end
                end

                LOCKING: begin
                    if (!legal) begin
                        state <= HUNT;
                        good  <= 4'd0;
                    end else if (in_order) begin
                        prev_idx <= idx;
                        good     <= good_inc;
                        if (good_inc == LOCK_TARGET) begin
                            state  <= TRACK;
                            Locked <= 1'b1;
                        end
                    end else if (hold && HOLD_OK) begin
                        // tolerated repeat: nothing changes
                    end else begin
                        // out-of-order legal sample restarts the lock count
                        prev_idx <= idx;
                        good     <= 4'd1;
                    end
                end

                TRACK: begin
                    if (in_order) begin
                        prev_idx <= idx;
                        if (idx == 2'd0) begin
                            Cycle_Count <= Cycle_Count + CNT_ONE;
                        end
                    end else if (hold && HOLD_OK) begin
                        // tolerated repeat: nothing changes
                    end else begin
                        state   <= FAULT;
                        Locked  <= 1'b0;
                        Seq_Err <= 1'b1;
`ifdef PHASE_ERR_CNT_EN
                        if (Err_Clr) begin
                            Err_Count <= 8'd1;
                        end else if (Err_Count != 8'hFF) begin
                            Err_Count <= Err_Count + 8'd1;
                        end
`endif
                    end
                end

                FAULT: begin
                    // one-cycle penalty; the sample on this edge is ignored
                    state <= HUNT;
                    good  <= 4'd0;
                end

                default: begin
                    state <= HUNT;
                    good  <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
